// File: rtl/fs_pkg.sv
// Constants and state encoding shared by the FT2232H fast-serial receiver and transmitter.
package fs_pkg;

  localparam int   FS_DATA_BITS = 8;
  localparam int   FS_GUARD_LEN = 10;

  localparam logic FS_SRC_A   = 1'b0;
  localparam logic FS_SRC_B   = 1'b1;
  localparam int   FS_SRC_ANY = 2;

  typedef enum logic [1:0] {
    FS_ST_GUARD,
    FS_ST_IDLE,
    FS_ST_DATA,
    FS_ST_SRC
  } fs_rx_state_e;

endpackage

// File: rtl/fs_rx_fifo.sv
// First-word fall-through FIFO holding {source, data} entries for the fast-serial receiver.
module fs_rx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately left out of reset; entries are only read
  // once written, so the pointers alone define the FIFO contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/fsdo_receiver.sv
// FSDO frame decoder (start, 8 data bits LSB first, source bit) feeding a valid/ready FWFT FIFO.
module fsdo_receiver
  import fs_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ACCEPT_SRC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       FSDO,
  output logic [7:0] rx_data,
  output logic       rx_src,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overflow,
  output logic       LED
);

  localparam int             GW         = $clog2(FS_GUARD_LEN);
  localparam logic [GW-1:0]  GUARD_LAST = GW'(FS_GUARD_LEN - 1);
  localparam logic [GW-1:0]  GUARD_ONE  = GW'(1);
  localparam logic [2:0]     BIT_LAST   = 3'(FS_DATA_BITS - 1);
  localparam logic [2:0]     BIT_ONE    = 3'd1;

  fs_rx_state_e            state_q, state_d;
  logic                    fsdo_q;
  logic [GW-1:0]           guard_cnt_q, guard_cnt_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [FS_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                    overflow_q, led_q;

  logic                    src_pass, push_req, push_ok, pop;
  logic                    fifo_full, fifo_empty;
  logic [FS_DATA_BITS:0]   fifo_head;

  assign src_pass = (ACCEPT_SRC == FS_SRC_ANY) || (fsdo_q == 1'(ACCEPT_SRC));

  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    push_req    = 1'b0;
    unique case (state_q)
      FS_ST_GUARD: begin
        if (!fsdo_q) begin
          guard_cnt_d = '0;
        end else if (guard_cnt_q == GUARD_LAST) begin
          guard_cnt_d = '0;
          state_d     = FS_ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + GUARD_ONE;
        end
      end
      FS_ST_IDLE: begin
        if (!fsdo_q) begin
          bit_cnt_d = '0;
          state_d   = FS_ST_DATA;
        end
      end
      FS_ST_DATA: begin
        shreg_d   = {fsdo_q, shreg_q[FS_DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + BIT_ONE;
        if (bit_cnt_q == BIT_LAST) state_d = FS_ST_SRC;
      end
      FS_ST_SRC: begin
        push_req = src_pass;
        state_d  = FS_ST_IDLE;
      end
      default: state_d = FS_ST_GUARD;
    endcase
  end

  assign pop     = rx_valid && rx_ready;
  assign push_ok = push_req && (!fifo_full || pop);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsdo_q      <= 1'b1;
      state_q     <= FS_ST_GUARD;
      guard_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      overflow_q  <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      fsdo_q      <= FSDO;
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      overflow_q  <= overflow_q | (push_req && fifo_full && !pop);
      led_q       <= led_q ^ push_ok;
    end
  end

  fs_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FS_DATA_BITS + 1)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_req),
    .push_data_i ({fsdo_q, shreg_q}),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Head is forced to zero while empty so the outputs have defined reset values.
  assign rx_valid          = !fifo_empty;
  assign {rx_src, rx_data} = fifo_empty ? '0 : fifo_head;
  assign overflow          = overflow_q;
  assign LED               = led_q;

endmodule

// File: tb/tb_fsdo_receiver.sv
// Directed bench for fsdo_receiver: default instance plus a channel-A-only instance.
module tb_fsdo_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fsdo, fsdo_a;
  logic       rx_ready, ready_a;
  logic [7:0] rx_data, data_a;
  logic       rx_src, src_a;
  logic       rx_valid, valid_a;
  logic       overflow, overflow_a;
  logic       led, led_a;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsdo_receiver #(.FIFO_DEPTH(2), .ACCEPT_SRC(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .FSDO     (fsdo),
    .rx_data  (rx_data),
    .rx_src   (rx_src),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overflow (overflow),
    .LED      (led)
  );

  fsdo_receiver #(.FIFO_DEPTH(2), .ACCEPT_SRC(0)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .FSDO     (fsdo_a),
    .rx_data  (data_a),
    .rx_src   (src_a),
    .rx_valid (valid_a),
    .rx_ready (ready_a),
    .overflow (overflow_a),
    .LED      (led_a)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit to_a);
    @(negedge clk);
    if (to_a) fsdo_a = b;
    else      fsdo   = b;
  endtask

  task automatic idle(input int n, input bit to_a);
    repeat (n) send_bit(1'b1, to_a);
  endtask

  task automatic frame(input logic [7:0] d, input logic s, input bit to_a);
    send_bit(1'b0, to_a);
    for (int i = 0; i < 8; i++) send_bit(d[i], to_a);
    send_bit(s, to_a);
  endtask

  initial begin
    logic [7:0] cut;
    rst_n    = 1'b0;
    fsdo     = 1'b1;
    fsdo_a   = 1'b1;
    rx_ready = 1'b0;
    ready_a  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances
    check("rst_valid",    rx_valid,          9'h0);
    check("rst_head",     {rx_src, rx_data}, 9'h000);
    check("rst_overflow", overflow,          9'h0);
    check("rst_led",      led,               9'h0);
    check("rst_a_valid",  valid_a,           9'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame 0xA5 src B, consumer always ready
    idle(12, 0);
    rx_ready = 1'b1;
    frame(8'hA5, 1'b1, 0);
    idle(1, 0);
    check("a5_not_yet", rx_valid, 9'h0);
    idle(1, 0);
    check("a5_valid", rx_valid,          9'h1);
    check("a5_head",  {rx_src, rx_data}, 9'h1A5);
    check("a5_led",   led,               9'h1);
    idle(1, 0);
    check("a5_popped", rx_valid, 9'h0);

    // Full FIFO with a pop on the push edge: accepted, no overflow
    rx_ready = 1'b0;
    frame(8'h11, 1'b0, 0);
    frame(8'h22, 1'b1, 0);
    idle(2, 0);
    check("full_head", {rx_src, rx_data}, 9'h011);
    frame(8'h33, 1'b0, 0);
    send_bit(1'b1, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("pp_head",     {rx_src, rx_data}, 9'h122);
    check("pp_overflow", overflow,          9'h0);
    check("pp_led",      led,               9'h0);
    rx_ready = 1'b1;
    @(negedge clk);
    check("pp_next", {rx_src, rx_data}, 9'h033);
    @(negedge clk);
    check("pp_empty", rx_valid, 9'h0);
    rx_ready = 1'b0;

    // Three back-to-back frames into a depth-2 FIFO, consumer stalled
    frame(8'h01, 1'b0, 0);
    frame(8'h02, 1'b1, 0);
    frame(8'h03, 1'b0, 0);
    idle(1, 0);
    check("ovf_not_yet", overflow, 9'h0);
    idle(1, 0);
    check("ovf_set",  overflow,          9'h1);
    check("ovf_head", {rx_src, rx_data}, 9'h001);
    check("ovf_led",  led,               9'h0);
    rx_ready = 1'b1;
    @(negedge clk);
    check("ovf_second", {rx_src, rx_data}, 9'h102);
    @(negedge clk);
    check("ovf_drained", rx_valid, 9'h0);
    check("ovf_sticky",  overflow, 9'h1);
    rx_ready = 1'b0;
    frame(8'h44, 1'b1, 0);
    idle(2, 0);
    check("pre_rst_head", {rx_src, rx_data}, 9'h144);
    check("pre_rst_led",  led,               9'h1);

    // Channel-A-only instance drops src B frames silently
    frame(8'h55, 1'b1, 1);
    frame(8'h66, 1'b0, 1);
    idle(1, 1);
    check("flt_none", valid_a, 9'h0);
    idle(1, 1);
    check("flt_valid",    valid_a,         9'h1);
    check("flt_head",     {src_a, data_a}, 9'h066);
    check("flt_overflow", overflow_a,      9'h0);
    check("flt_led",      led_a,           9'h1);

    // Reset asserted at data bit 4, remainder of the frame must be ignored
    cut = 8'h5A;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(cut[i], 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    rx_valid,          9'h0);
    check("mid_rst_head",     {rx_src, rx_data}, 9'h000);
    check("mid_rst_overflow", overflow,          9'h0);
    check("mid_rst_led",      led,               9'h0);
    for (int i = 4; i < 8; i++) begin
      send_bit(cut[i], 0);
      if (i == 4) rst_n = 1'b1;
    end
    send_bit(1'b0, 0);
    idle(15, 0);
    check("rem_no_push", rx_valid, 9'h0);
    check("rem_led",     led,      9'h0);

    // Release during mid-frame bits; guard needs exactly ten highs
    @(negedge clk);
    rst_n = 1'b0;
    fsdo  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    idle(9, 0);
    frame(8'h3C, 1'b0, 0);
    idle(2, 0);
    check("guard9_reject", rx_valid, 9'h0);
    idle(8, 0);
    frame(8'h3C, 1'b0, 0);
    idle(1, 0);
    check("guard10_not_yet", rx_valid, 9'h0);
    idle(1, 0);
    check("guard10_valid", rx_valid,          9'h1);
    check("guard10_head",  {rx_src, rx_data}, 9'h03C);
    check("guard10_led",   led,               9'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
